// File: rtl/fetch_queue_unit_pkg.sv
// Shared widths, constants, fetch state encodings and the queue entry layout
// for the prefetching instruction fetcher.
package fetch_queue_unit_pkg;

    localparam int unsigned ADDR_LEN = 32;
    localparam int unsigned INS_LEN  = 32;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [ADDR_LEN-1:0] ZERO_ADDR = '0;

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StFetch = 1'b1;

    typedef struct packed {
        logic [INS_LEN-1:0]  inst;
        logic [ADDR_LEN-1:0] pc;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Instruction port between the fetcher (master) and memctrl (slave).
interface fetch_queue_unit_if;
    import fetch_queue_unit_pkg::*;

    logic [ADDR_LEN-1:0] pc_to_mc;
    logic                ena_to_mc;
    logic                drop_flag_to_mc;
    logic                ok_flag_from_mc;
    logic [INS_LEN-1:0]  inst_from_mc;

    modport master (
        output pc_to_mc,
        output ena_to_mc,
        output drop_flag_to_mc,
        input  ok_flag_from_mc,
        input  inst_from_mc
    );

    modport slave (
        input  pc_to_mc,
        input  ena_to_mc,
        input  drop_flag_to_mc,
        output ok_flag_from_mc,
        output inst_from_mc
    );

endinterface

// File: rtl/fetch_queue_unit_inst_fifo.sv
// Prefetch FIFO of {inst, pc} entries with push/pop/flush; head entry is
// presented combinationally so the dispatch register can load it on pop.
module fetch_queue_unit_inst_fifo
    import fetch_queue_unit_pkg::*;
#(
    parameter int unsigned Depth = 4,
    parameter int unsigned PtrW  = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push_i,
    input  logic      pop_i,
    input  logic      flush_i,
    input  fq_entry_t wdata_i,
    output fq_entry_t rdata_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int unsigned CntW = PtrW + 1;

    fq_entry_t           mem_q [Depth];
    logic [PtrW-1:0]     head_q, head_d;
    logic [PtrW-1:0]     tail_q, tail_d;
    logic [CntW-1:0]     count_q, count_d;

    assign rdata_o = mem_q[head_q];
    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Pointer width equals log2(Depth), so increment wraps for free.
            if (push_i) tail_d = tail_q + 1'b1;
            if (pop_i)  head_d = head_q + 1'b1;
            if (push_i && !pop_i) begin
                count_d = count_q + 1'b1;
            end else if (pop_i && !push_i) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_i && !flush_i) begin
            mem_q[tail_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetcher with a prefetch queue: one outstanding memctrl request,
// registered dispatch from the queue head, ROB jump flushes everything.
module fetch_queue_unit
    import fetch_queue_unit_pkg::*;
#(
    parameter int unsigned         QUEUE_DEPTH = 4,
    parameter int unsigned         PTR_W       = 2,
    parameter logic [ADDR_LEN-1:0] RESET_PC    = ZERO_ADDR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    fetch_queue_unit_if.master  mc,
    input  logic                full_from_rs,
    input  logic                full_from_lsb,
    input  logic                full_from_rob,
    output logic                ok_flag_to_dsp,
    output logic [INS_LEN-1:0]  inst_to_dcd,
    output logic [ADDR_LEN-1:0] pc_to_dsp,
    input  logic                commit_jump_flag_from_rob,
    input  logic [ADDR_LEN-1:0] target_pc_from_rob
);

    logic [0:0]          state_q, state_d;
    logic [ADDR_LEN-1:0] fetch_pc_q, fetch_pc_d;
    logic                drop_q, drop_d;
    logic                ok_dsp_q, ok_dsp_d;
    logic [INS_LEN-1:0]  inst_dsp_q, inst_dsp_d;
    logic [ADDR_LEN-1:0] pc_dsp_q, pc_dsp_d;

    logic      ena;
    logic      fifo_push, fifo_pop, fifo_flush;
    logic      fifo_full, fifo_empty;
    logic      any_full;
    fq_entry_t push_entry, head_entry;

    assign any_full        = full_from_rs | full_from_lsb | full_from_rob;
    assign push_entry.inst = mc.inst_from_mc;
    assign push_entry.pc   = fetch_pc_q;

    assign mc.pc_to_mc        = fetch_pc_q;
    assign mc.ena_to_mc       = ena;
    assign mc.drop_flag_to_mc = drop_q;

    assign ok_flag_to_dsp = ok_dsp_q;
    assign inst_to_dcd    = inst_dsp_q;
    assign pc_to_dsp      = pc_dsp_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        drop_d     = FALSE;
        ok_dsp_d   = FALSE;
        inst_dsp_d = inst_dsp_q;
        pc_dsp_d   = pc_dsp_q;
        ena        = FALSE;
        fifo_push  = FALSE;
        fifo_pop   = FALSE;
        fifo_flush = FALSE;
        if (rst) begin
            // Outputs stay quiet while reset is held; state is cleared by the flops.
            ena = FALSE;
        end else if (commit_jump_flag_from_rob) begin
            // Any memctrl response this cycle belongs to the abandoned path.
            fetch_pc_d = target_pc_from_rob;
            fifo_flush = TRUE;
            state_d    = StIdle;
            drop_d     = TRUE;
        end else if (rdy) begin
            unique case (state_q)
                StIdle: begin
                    if (!fifo_full) begin
                        ena     = TRUE;
                        state_d = StFetch;
                    end
                end
                StFetch: begin
                    if (mc.ok_flag_from_mc) begin
                        fifo_push  = TRUE;
                        fetch_pc_d = fetch_pc_q + ADDR_LEN'(4);
                        state_d    = StIdle;
                    end
                end
            endcase
            if (!any_full && !fifo_empty) begin
                fifo_pop   = TRUE;
                ok_dsp_d   = TRUE;
                inst_dsp_d = head_entry.inst;
                pc_dsp_d   = head_entry.pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            drop_q     <= FALSE;
            ok_dsp_q   <= FALSE;
            inst_dsp_q <= '0;
            pc_dsp_q   <= ZERO_ADDR;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
            ok_dsp_q   <= ok_dsp_d;
            inst_dsp_q <= inst_dsp_d;
            pc_dsp_q   <= pc_dsp_d;
        end
    end

    fetch_queue_unit_inst_fifo #(
        .Depth (QUEUE_DEPTH),
        .PtrW  (PTR_W)
    ) u_inst_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .wdata_i (push_entry),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule
